// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode map, sequencer state and
// opcode classification helpers.
package alu_pkg;

  localparam int OPW = 5;

  typedef logic [OPW-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 5'd0,
                      OP_ADC  = 5'd1,
                      OP_SUB  = 5'd2,
                      OP_SBB  = 5'd3,
                      OP_MUL  = 5'd4,
                      OP_AND  = 5'd8,
                      OP_OR   = 5'd9,
                      OP_XOR  = 5'd10,
                      OP_NAND = 5'd11,
                      OP_NOR  = 5'd12,
                      OP_XNOR = 5'd13,
                      OP_NOT  = 5'd14,
                      OP_NEG  = 5'd15;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  // Codes 5-7 are reserved for floating point, 16 and up are unassigned.
  function automatic logic is_illegal(opcode_t op);
    return ((op >= 5'd5) && (op <= 5'd7)) || (op > OP_NEG);
  endfunction

  function automatic logic is_add_class(opcode_t op);
    return (op <= OP_SBB) || (op == OP_NEG);
  endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result handshake bundle between operand fetch, the ALU and
// register writeback. The ALU is the slave side.
interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  opcode_t          opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;
  logic             err_illegal;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v, err_illegal
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v, err_illegal
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b, one
// multiplier bit per cycle; done pulses alongside the final product.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;

  // The product is taken from the adder of the last step, so the consumer can
  // capture it on the same edge that would have written acc.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign product  = acc_next;
  assign done     = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, persistent carry for ADC/SBB
// chaining and a sequenced shift-add multiplier.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  state_t           state;
  logic             c_reg;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             add_ovf;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  logic             load_alu;
  logic [WIDTH-1:0] ld_res;
  logic             ld_c;
  logic             ld_v;
  logic             ld_err;

  assign bus.in_ready = (state == ST_IDLE) && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign mul_start    = accept && (bus.opcode == OP_MUL);
  assign load_alu     = accept && (bus.opcode != OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single adder shared by all add-class ops; NEG is 0 + ~a + 1.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case can leave a value held (which infers a latch).
    add_x   = bus.a;
    add_y   = bus.b;
    add_cin = 1'b0;
    case (bus.opcode)
      OP_ADC: add_cin = c_reg;
      OP_SUB: begin add_y = ~bus.b; add_cin = 1'b1;  end
      OP_SBB: begin add_y = ~bus.b; add_cin = c_reg; end
      OP_NEG: begin add_x = '0; add_y = ~bus.a; add_cin = 1'b1; end
      default: ;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+1)'(add_cin);
  assign add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != add_x[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_c   = c_reg;
    alu_v   = 1'b0;
    case (bus.opcode)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_NEG: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = add_ovf;
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NAND: alu_res = ~(bus.a & bus.b);
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_XNOR: alu_res = ~(bus.a ^ bus.b);
      OP_NOT:  alu_res = ~bus.a;
      default: alu_res = '0;
    endcase
  end

  // mul_done can only be high in ST_MUL, when no new op is being accepted.
  assign ld_res = mul_done ? mul_prod : alu_res;
  assign ld_c   = mul_done ? c_reg    : alu_c;
  assign ld_v   = !mul_done && alu_v;
  assign ld_err = !mul_done && is_illegal(bus.opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      c_reg           <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.result      <= '0;
      bus.flag_c      <= 1'b0;
      bus.flag_z      <= 1'b0;
      bus.flag_n      <= 1'b0;
      bus.flag_v      <= 1'b0;
      bus.err_illegal <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        ST_IDLE: if (mul_start) state <= ST_MUL;
        ST_MUL:  if (mul_done)  state <= ST_IDLE;
      endcase

      if (load_alu || mul_done) begin
        bus.out_valid   <= 1'b1;
        bus.result      <= ld_res;
        bus.flag_c      <= ld_c;
        bus.flag_z      <= (ld_res == '0);
        bus.flag_n      <= ld_res[WIDTH-1];
        bus.flag_v      <= ld_v;
        bus.err_illegal <= ld_err;
      end else if (bus.out_ready) begin
        bus.out_valid   <= 1'b0;
      end

      if (load_alu && is_add_class(bus.opcode)) c_reg <= alu_c;
    end
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the processor's decoded-opcode ALU. It implements the integer and logical operations of the existing 5-bit opcode map at generic width and uses a valid/ready handshake on both sides. It keeps a persistent carry flag so that add-with-carry and subtract-with-borrow chain correctly, and performs multiplication with an iterative shift-add unit. It sits between operand fetch and register writeback.

## Interface
- WIDTH, 32, operand/result width (≥ 4)
- OPW, 5, opcode width (fixed map below; upper codes illegal)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  ALU can accept a new operation
- opcode  in  OPW  operation select
- a, b  in  WIDTH  operands
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  result
- flag_c, flag_z, flag_n, flag_v  out  1  carry, zero, negative, signed overflow of `result`
- err_illegal  out  1  `result` belongs to an unimplemented opcode

## Operation
- Opcode map: 0 ADD a+b; 1 ADC a+b+C; 2 SUB a+~b+1; 3 SBB a+~b+C; 4 MUL low WIDTH bits of a*b (unsigned); 5–7 reserved (float); 8 AND; 9 OR; 10 XOR; 11 NAND; 12 NOR; 13 XNOR; 14 NOT a; 15 NEG (~a+1); 16–31 reserved.
- C is the internal carry register. For SUB/SBB, C=1 means no borrow.
- Add-class ops (0–3, 15):
  - flag_c = carry out of bit WIDTH-1. NEG sets flag_c=1 only for a=0.
  - flag_v = signed overflow of the addition as performed.
- MUL and logic ops: flag_c = current C (unchanged), flag_v = 0.
- flag_z = (result==0); flag_n = result[WIDTH-1]; both apply to all legal ops.
- Reserved opcodes: result=0, err_illegal=1, flag_z=1, flag_c=C, other flags 0.
- C register:
  - Loads flag_c when the output register is loaded by a legal add-class op; all other ops leave it unchanged.
  - Reset value is 0.
- FSM states:
  - IDLE: accept on in_valid&&in_ready. Non-MUL ops load the output register directly. MUL goes to MUL.
  - MUL: one partial-product step per cycle for WIDTH cycles. After the last step, load the output register and return to IDLE.
- Operands and opcode are captured at acceptance. Input changes after acceptance have no effect.

## Timing
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational from out_ready.
- Non-MUL latency: accepted at edge k → out_valid=1 after edge k.
- Non-MUL throughput: one op per cycle while out_ready=1.
- MUL latency: accepted at edge k → out_valid=1 after edge k+WIDTH. in_ready=0 throughout.
- The output register holds result, flags and err_illegal stable while out_valid && !out_ready.
- out_valid clears on handshake unless a new result loads on the same edge.
- Simultaneous accept and output handshake on one edge: new result replaces the old. There is no bubble.
- ADC/SBB issued back-to-back use the C produced by the immediately preceding accepted op.
- Reset (asserted at any time, including mid-MUL):
  - state=IDLE; out_valid=0; result=0; all flags 0; err_illegal=0; C=0.
  - Any partial multiply is discarded.
  - in_ready=1 once rst_n deasserts.

## Structure
- Package alu_pkg: opcode localparams (OP_ADD…OP_NEG), FSM state enum, function `is_illegal(opcode)`.
- Sub-module alu_mul_seq:
  - Inputs: start, a, b. Outputs: done pulse, WIDTH-bit product.
  - Shift-add, one bit per cycle, same clk/rst_n.
  - The top FSM sequences it.
- Remaining datapath (adder with configurable cin/b-invert, logic mux, flag generation) lives in alu_pipe.

## Test plan
- WIDTH=32:
  - ADD 0xFFFFFFFF+1 → result 0, C=1, Z=1, V=0.
  - Then ADC 0+0 → result 1, Z=0.
- SUB 5−7 → 0xFFFFFFFE, C=0, N=1. Then SBB 10−3 → 6 (borrow consumed).
- ADD 0x7FFFFFFF+1 → 0x80000000, V=1, N=1.
- MUL 0x10000*0x10003 → 0x00030000.
  - out_valid rises exactly 32 cycles after acceptance; in_ready=0 meanwhile.
- Backpressure: hold out_ready=0 for 5 cycles after XOR 0xF0F0F0F0^0xFFFFFFFF.
  - result stays 0x0F0F0F0F; in_ready=0.
  - Release out_ready → next queued op accepted the same edge.
- Opcode 6 → err_illegal=1, result 0, C unchanged.
- Assert rst_n low mid-MUL → all outputs 0 immediately; the next ADD 2+3 returns 5 after one cycle.
